uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters.
- Each requester presents bytes over a valid/ready interface with a last-byte marker.
- Round-robin arbitration; the grant is held for one packet, up to MAX_BURST bytes.
- Drives the transmitter's send/tx_data inputs and consumes its tx_data_ready. Sits between firmware/DMA byte sources and the TX datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width forwarded to the transmitter
- MAX_BURST, 16, max bytes per grant before forced release (1..255)
- IDLE_TIMEOUT, 64, cycles a granted requester may hold valid low before the grant is revoked (1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  1 = new grants allowed
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is the final byte of the packet
- req_ready  out  NUM_REQ  byte accepted this cycle
- tx_data_ready  in  1  transmitter can take a byte
- send  out  1  byte offered to transmitter
- tx_data  out  DATA_W  byte to transmitter
- grant_valid  out  1  a requester currently holds the transmitter
- grant_id  out  clog2(NUM_REQ)  index of granted requester
- timeout_evt  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset values:
  - state = ARB; rr_ptr = 0; grant_id = 0; grant_valid = 0.
  - burst_cnt = 0; idle_cnt = 0.
  - send = 0; req_ready = 0; tx_data = 0; timeout_evt = 0.
- Transfer: a byte moves on any cycle where send && tx_data_ready.
  - req_ready[grant_id] = send && tx_data_ready. All other req_ready bits are 0.
- ARB state:
  - send = 0; grant_valid = 0.
  - If enable && |req_valid: pick the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register that index into grant_id, clear burst_cnt and idle_cnt, go to OWN.
  - Arbitration latency is 1 cycle: the first byte can transfer no earlier than the cycle after the request is seen.
- OWN state:
  - grant_valid = 1.
  - send = req_valid[grant_id]; tx_data = req_data[grant_id]. Both combinational from the granted lane.
  - On transfer: burst_cnt += 1; idle_cnt cleared.
  - Release to ARB on the transfer cycle when req_last = 1, or when burst_cnt reaches MAX_BURST-1 (i.e. the MAX_BURST-th byte).
  - If both release conditions occur on the same transfer: one ordinary release.
  - When req_valid[grant_id] = 0: idle_cnt += 1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 with valid still low: release to ARB and pulse timeout_evt for 1 cycle.
  - Timeout versus valid rising in the same cycle: valid wins, idle_cnt clears, no timeout.
- On every release: rr_ptr = grant_id + 1, wrapping NUM_REQ-1 -> 0.
- After a release, ARB re-arbitrates on the next cycle. A just-released requester has lowest priority.
- tx_data_ready low while send is high: send and tx_data hold, no counters change. The timeout does not advance, because valid is high.
- enable falling during OWN: the current grant completes normally. Only new grants are blocked.
- req_valid of non-granted lanes is ignored in OWN.
- Reset asserted mid-packet: all state clears immediately and the partial packet is abandoned. The transmitter finishes any byte already accepted, since that is its own behaviour.
- Counter widths: burst_cnt and idle_cnt are 8 bits. They never wrap, because release occurs at the limit.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_data_ready always 1 -> send high for 3 consecutive cycles starting 1 cycle after valid, req_ready[0] pulses 3 times, grant_valid drops the cycle after 0x43, rr_ptr = 1.
- Fairness: req0..req3 all valid, each packet 1 byte with last=1 -> grant order 0,1,2,3,0; each grant lasts 1 cycle followed by 1 ARB cycle.
- Burst limit: MAX_BURST=16, req2 streams 20 bytes without last, req1 also valid -> req2 released after its 16th byte, req1 granted next, req2 regranted afterwards and sends its remaining 4.
- Backpressure: tx_data_ready toggles 1,0,0,1 while req1 sends 0xA5,0x5A -> tx_data stable at 0xA5 through the low cycles, exactly 2 req_ready pulses, no duplicates.
- Timeout: IDLE_TIMEOUT=64, req3 granted, sends 1 byte without last, then drops valid -> timeout_evt pulses on the 64th idle cycle, grant_valid = 0 the next cycle; a repeat run with valid reasserted on idle cycle 64 -> no timeout.
- Enable/reset: enable=0 with req0 valid -> no grant for 10 cycles; enable=1 -> grant. Then assert rst_n low mid-packet -> send, grant_valid and req_ready go 0 immediately, rr_ptr = 0 after reset.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte streams; grant held per packet (<= MAX_BURST bytes).
// One-cycle arbitration, then bytes pass combinationally; tx_data_ready low stalls the granted lane in place.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 64,
  localparam int IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_data_ready,
  output logic                      send,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_id,
  output logic                      timeout_evt
);

  typedef enum logic {ARB, OWN} state_t;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] IDLE_LAST  = 8'(IDLE_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr, rr_d;
  logic [IW-1:0] grant_d;
  logic [7:0]    burst_cnt, burst_d;
  logic [7:0]    idle_cnt, idle_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;
  logic          lane_vld;
  logic          lane_last;
  logic [DATA_W-1:0] lane_dat;
  logic          xfer;
  logic [IW-1:0] next_ptr;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NUM_REQ);
  endfunction

  // Scan from the far end so the candidate closest to rr_ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = wrap_idx(int'(rr_ptr) + i);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign lane_vld  = req_valid[grant_id];
  assign lane_last = req_last[grant_id];
  assign lane_dat  = req_data[int'(grant_id)*DATA_W +: DATA_W];
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign xfer      = send && tx_data_ready;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_ptr;
    grant_d     = grant_id;
    burst_d     = burst_cnt;
    idle_d      = idle_cnt;
    send        = 1'b0;
    tx_data     = '0;
    req_ready   = '0;
    grant_valid = 1'b0;
    timeout_evt = 1'b0;

    case (state_q)
      ARB: begin
        if (enable && pick_found) begin
          grant_d = pick_idx;
          burst_d = '0;
          idle_d  = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        grant_valid         = 1'b1;
        send                = lane_vld;
        tx_data             = lane_dat;
        req_ready[grant_id] = xfer;
        if (xfer) begin
          burst_d = burst_cnt + 8'd1;
          idle_d  = '0;
          if (lane_last || burst_cnt == BURST_LAST) begin
            state_d = ARB;
            rr_d    = next_ptr;
          end
        end else if (lane_vld) begin
          // Stalled by the transmitter: the requester is not idle.
          idle_d = '0;
        end else if (idle_cnt == IDLE_LAST) begin
          timeout_evt = 1'b1;
          state_d     = ARB;
          rr_d        = next_ptr;
        end else begin
          idle_d = idle_cnt + 8'd1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB;
      rr_ptr    <= '0;
      grant_id  <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      grant_id  <= grant_d;
      burst_cnt <= burst_d;
      idle_cnt  <= idle_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single packet, fairness, burst limit, backpressure, timeout, enable/reset.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_data_ready;
  logic        send;
  logic [7:0]  tx_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_evt;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .DATA_W(8), .MAX_BURST(16), .IDLE_TIMEOUT(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_data_ready(tx_data_ready),
    .send(send), .tx_data(tx_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    tx_data_ready = 1'b1; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; enable = 1'b1; tx_data_ready = 1'b1;
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if (send !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'h0 || tx_data !== 8'h00 || timeout_evt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs send=%b gv=%b rdy=%b txd=%h to=%b want all 0", send, grant_valid, req_ready, tx_data, timeout_evt);
    end
    repeat (3) cyc();
    checks++;
    if (grant_id !== 2'd0 || dut.rr_ptr !== 2'd0 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state gid=%0d rr=%0d gv=%b want 0 0 0", grant_id, dut.rr_ptr, grant_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid[0] = 1'b1; set_lane(0, 8'h41);
    #1;
    checks++;
    if (send !== 1'b0 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL single_arb send=%b gv=%b want 0 0", send, grant_valid);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      set_lane(0, 8'(8'h41 + k)); req_last[0] = (k == 2);
      #1;
      checks++;
      if (send !== 1'b1 || tx_data !== 8'(8'h41 + k) || req_ready !== 4'b0001 || grant_id !== 2'd0) begin
        errors++;
        $display("FAIL single_byte%0d send=%b txd=%h rdy=%b gid=%0d want 1 %h 0001 0", k, send, tx_data, req_ready, grant_id, 8'(8'h41 + k));
      end
    end
    cyc();
    req_valid = '0; req_last = '0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || send !== 1'b0 || dut.rr_ptr !== 2'd1) begin
      errors++; $display("FAIL single_release gv=%b send=%b rr=%0d want 0 0 1", grant_valid, send, dut.rr_ptr);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_rdy;
    int lane;
    do_reset();
    req_valid = 4'hF; req_last = 4'hF; req_data = 32'h13121110;
    for (int g = 0; g < 5; g++) begin
      lane = g % 4;
      exp_rdy = 4'b0001 << lane;
      #1;
      checks++;
      if (grant_valid !== 1'b0 || send !== 1'b0) begin
        errors++; $display("FAIL fair_arb%0d gv=%b send=%b want 0 0", g, grant_valid, send);
      end
      cyc(); #1;
      checks++;
      if (grant_valid !== 1'b1 || grant_id !== 2'(lane) || tx_data !== 8'(8'h10 + lane) || req_ready !== exp_rdy) begin
        errors++;
        $display("FAIL fair_grant%0d gv=%b gid=%0d txd=%h rdy=%b want 1 %0d %h %b", g, grant_valid, grant_id, tx_data, req_ready, lane, 8'(8'h10 + lane), exp_rdy);
      end
      cyc();
    end
  endtask

  task automatic test_burst();
    int bad;
    do_reset();
    req_valid[2] = 1'b1; set_lane(2, 8'd0);
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      cyc();
      set_lane(2, 8'(n));
      if (n == 1) begin req_valid[1] = 1'b1; req_last[1] = 1'b1; set_lane(1, 8'hB1); end
      #1;
      if (grant_id !== 2'd2 || send !== 1'b1 || tx_data !== 8'(n) || req_ready !== 4'b0100) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL burst_first16 bad_cycles=%0d want 0", bad); end
    cyc();
    set_lane(2, 8'd16);
    #1;
    checks++;
    if (grant_valid !== 1'b0) begin errors++; $display("FAIL burst_release gv=%b want 0", grant_valid); end
    cyc(); #1;
    checks++;
    if (grant_id !== 2'd1 || tx_data !== 8'hB1 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL burst_req1 gid=%0d txd=%h rdy=%b want 1 b1 0010", grant_id, tx_data, req_ready);
    end
    cyc();
    req_valid[1] = 1'b0; req_last[1] = 1'b0;
    #1;
    bad = 0;
    for (int n = 16; n < 20; n++) begin
      cyc();
      set_lane(2, 8'(n)); req_last[2] = (n == 19);
      #1;
      if (grant_id !== 2'd2 || tx_data !== 8'(n) || req_ready !== 4'b0100) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL burst_rest bad_cycles=%0d want 0", bad); end
    cyc();
    req_valid = '0; req_last = '0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || dut.rr_ptr !== 2'd3) begin
      errors++; $display("FAIL burst_end gv=%b rr=%0d want 0 3", grant_valid, dut.rr_ptr);
    end
  endtask

  task automatic test_backpressure();
    int pulses;
    do_reset();
    pulses = 0;
    req_valid[1] = 1'b1; set_lane(1, 8'hA5); tx_data_ready = 1'b1;
    #1;
    pulses += int'(req_ready[1]);
    for (int k = 0; k < 2; k++) begin
      cyc();
      tx_data_ready = 1'b0;
      #1;
      pulses += int'(req_ready[1]);
      checks++;
      if (send !== 1'b1 || tx_data !== 8'hA5 || req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_stall%0d send=%b txd=%h rdy=%b want 1 a5 0000", k, send, tx_data, req_ready);
      end
    end
    cyc();
    tx_data_ready = 1'b1;
    #1;
    pulses += int'(req_ready[1]);
    checks++;
    if (tx_data !== 8'hA5 || req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_first txd=%h rdy=%b want a5 0010", tx_data, req_ready);
    end
    cyc();
    set_lane(1, 8'h5A); req_last[1] = 1'b1;
    #1;
    pulses += int'(req_ready[1]);
    checks++;
    if (tx_data !== 8'h5A || req_ready !== 4'b0010) begin
      errors++; $display("FAIL bp_second txd=%h rdy=%b want 5a 0010", tx_data, req_ready);
    end
    cyc();
    req_valid = '0; req_last = '0;
    #1;
    pulses += int'(req_ready[1]);
    checks++;
    if (pulses != 2 || grant_valid !== 1'b0) begin
      errors++; $display("FAIL bp_pulses count=%0d gv=%b want 2 0", pulses, grant_valid);
    end
  endtask

  task automatic test_timeout(input bit reassert);
    int early;
    do_reset();
    early = 0;
    req_valid[3] = 1'b1; set_lane(3, 8'h33);
    #1;
    cyc(); #1;
    checks++;
    if (send !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000) begin
      errors++; $display("FAIL to_byte%0d send=%b gid=%0d rdy=%b want 1 3 1000", reassert, send, grant_id, req_ready);
    end
    cyc();
    req_valid[3] = 1'b0;
    for (int k = 1; k < 64; k++) begin
      #1;
      early += int'(timeout_evt) + int'(!grant_valid);
      cyc();
    end
    if (reassert) begin req_valid[3] = 1'b1; req_last[3] = 1'b1; set_lane(3, 8'h34); end
    #1;
    checks++;
    if (early != 0) begin errors++; $display("FAIL to_early%0d events=%0d want 0", reassert, early); end
    checks++;
    if (reassert) begin
      if (timeout_evt !== 1'b0 || send !== 1'b1 || tx_data !== 8'h34 || req_ready !== 4'b1000) begin
        errors++; $display("FAIL to_valid_wins to=%b send=%b txd=%h rdy=%b want 0 1 34 1000", timeout_evt, send, tx_data, req_ready);
      end
    end else begin
      if (timeout_evt !== 1'b1 || grant_valid !== 1'b1) begin
        errors++; $display("FAIL to_pulse to=%b gv=%b want 1 1", timeout_evt, grant_valid);
      end
    end
    cyc();
    req_valid = '0; req_last = '0;
    #1;
    checks++;
    if (grant_valid !== 1'b0 || timeout_evt !== 1'b0 || dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL to_after%0d gv=%b to=%b rr=%0d want 0 0 0", reassert, grant_valid, timeout_evt, dut.rr_ptr);
    end
  endtask

  task automatic test_enable_reset();
    int bad;
    do_reset();
    enable = 1'b0;
    req_valid[0] = 1'b1; set_lane(0, 8'h77);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      bad += int'(grant_valid) + int'(send);
      cyc();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_blocked events=%0d want 0", bad); end
    enable = 1'b1;
    cyc(); #1;
    checks++;
    if (grant_valid !== 1'b1 || send !== 1'b1 || req_ready !== 4'b0001) begin
      errors++; $display("FAIL en_grant gv=%b send=%b rdy=%b want 1 1 0001", grant_valid, send, req_ready);
    end
    cyc();
    set_lane(0, 8'h78);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (send !== 1'b0 || grant_valid !== 1'b0 || req_ready !== 4'h0 || dut.rr_ptr !== 2'd0) begin
      errors++; $display("FAIL rst_mid send=%b gv=%b rdy=%b rr=%0d want 0 0 0000 0", send, grant_valid, req_ready, dut.rr_ptr);
    end
    cyc();
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst();
    test_backpressure();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_enable_reset();
    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
